// File: rtl/mx_pkg.sv
// Shared definitions for the MX block quantizer: bf16/E8M0 field constants,
// controller state encoding and small helpers used by the top and the element converter.
package mx_pkg;

   localparam int BF16_W        = 16;
   localparam int BF16_MAN_W    = 7;
   localparam int BF16_BIAS     = 127;
   localparam int BF16_EXP_MAXF = 254;
   localparam int E8M0_BIAS     = 127;
   localparam logic [7:0] E8M0_NAN = 8'hFF;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_QUANT = 2'd1,
      ST_EMIT  = 2'd2
   } mx_state_e;

   function automatic int emax(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   // Subnormals flush to zero; Inf/NaN behave as the largest finite exponent.
   function automatic logic [7:0] bf16_exp_eff(input logic [7:0] e);
      if (e == 8'hFF) return 8'(BF16_EXP_MAXF);
      return e;
   endfunction

endpackage

// File: rtl/mx_elem_cvt.sv
// Combinational bf16 + shared E8M0 scale -> one narrow FP element (sign preserved, saturating).
// MX_QUANT_RNE_EN selects round-to-nearest-even; otherwise the discarded bits are truncated.
module mx_elem_cvt
   import mx_pkg::*;
#(
   parameter int exp_width   = 5,
   parameter int man_width   = 2,
   parameter int bit_width   = 8,
   parameter int scale_width = 8
) (
   input  logic [BF16_W-1:0]      i_data,
   input  logic [scale_width-1:0] i_scale,
   output logic [bit_width-1:0]   o_elem
);

   localparam int EMAX     = emax(exp_width);
   localparam int SH0      = BF16_MAN_W - man_width;
   localparam int CODE_MAX = (((1 << exp_width) - 1) << man_width) - 1;

   logic       sign;
   logic [7:0] exp_eff;
   logic [7:0] sig;
   logic [3:0] sh;
   int         eb_i;
   int         sh_i;
   int         base_i;
   int         q_i;
   int         code_i;

`ifdef MX_QUANT_RNE_EN
   function automatic int rne_inc(input logic [7:0] s, input logic [3:0] n, input logic lsb);
      logic [15:0] s16;
      logic        g;
      logic        st;
      s16 = {8'b0, s};
      g   = s16[n - 4'd1];
      st  = |(s16 & ((16'd1 << (n - 4'd1)) - 16'd1));
      return (g && (st || lsb)) ? 1 : 0;
   endfunction
`endif

   function automatic logic [bit_width-2:0] sat_code(input int code);
      if (code > CODE_MAX) return (bit_width-1)'(CODE_MAX);
      return (bit_width-1)'(code);
   endfunction

   // Encoded magnitude = (eb-1)<<man + significand, so a rounding carry walks into the exponent.
   always_comb begin
      sign    = i_data[15];
      exp_eff = bf16_exp_eff(i_data[14:7]);
      sig     = (i_data[14:7] == 8'hFF) ? 8'hFF : {1'b1, i_data[6:0]};
      eb_i    = int'(exp_eff) - BF16_BIAS - (int'(i_scale) - E8M0_BIAS) + EMAX;
      if (eb_i >= 1) begin
         sh_i   = SH0;
         base_i = (eb_i - 1) << man_width;
      end else begin
         sh_i   = SH0 + 1 - eb_i;
         base_i = 0;
      end
      if (sh_i > 9) sh_i = 9;
      sh  = 4'(sh_i);
      q_i = int'(sig >> sh);
`ifdef MX_QUANT_RNE_EN
      q_i = q_i + rne_inc(sig, sh, q_i[0]);
`endif
      code_i = base_i + q_i;
      o_elem = {sign, sat_code(code_i)};
      if (exp_eff == 8'd0) o_elem = {sign, {(bit_width-1){1'b0}}};
   end

endmodule

// File: rtl/mx_block_quantizer.sv
// Streaming MX encoder: gathers k bf16 values, derives the shared E8M0 scale and emits k elements.
// MX_QUANT_RNE_EN (in mx_elem_cvt) enables round-to-nearest-even; default truncates.
module mx_block_quantizer
   import mx_pkg::*;
#(
   parameter int k           = 4,
   parameter int exp_width   = 5,
   parameter int man_width   = 2,
   parameter int bit_width   = 8,
   parameter int scale_width = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [BF16_W-1:0]             i_data,
   input  logic                          i_last,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [k-1:0][bit_width-1:0]   o_X,
   output logic [scale_width-1:0]        o_S,
   output logic                          o_last
);

   localparam int EMAX  = emax(exp_width);
   localparam int CNT_W = (k > 1) ? $clog2(k) : 1;

   mx_state_e                    state;
   mx_state_e                    state_nxt;
   logic                         ready_fsm;
   logic                         accept;
   logic [CNT_W-1:0]             cnt;
   logic [7:0]                   exp_in;
   logic [7:0]                   max_exp_p0;
   logic                         last_p0;
   logic [k-1:0][BF16_W-1:0]     slot_p0;
   logic [k-1:0][bit_width-1:0]  cvt_x;
   logic [scale_width-1:0]       scale_c;
   int                           scale_i;

   assign o_ready = ready_fsm & i_rst_n;
   assign accept  = i_valid & o_ready;
   assign exp_in  = bf16_exp_eff(i_data[14:7]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_FILL;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_fsm = 1'b0;
      o_valid   = 1'b0;
      case (state)
         ST_FILL: begin
            ready_fsm = 1'b1;
            if (accept && ((cnt == CNT_W'(k - 1)) || i_last)) state_nxt = ST_QUANT;
         end
         ST_QUANT: state_nxt = ST_EMIT;
         ST_EMIT: begin
            o_valid = 1'b1;
            if (i_ready) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   always_comb begin
      scale_i = int'(max_exp_p0) - EMAX;
      if (scale_i < 0) scale_i = 0;
      if (scale_i > int'(E8M0_NAN) - 1) scale_i = int'(E8M0_NAN) - 1;
      scale_c = scale_width'(scale_i);
   end

   for (genvar g = 0; g < k; g++) begin : g_cvt
      mx_elem_cvt #(
         .exp_width  (exp_width),
         .man_width  (man_width),
         .bit_width  (bit_width),
         .scale_width(scale_width)
      ) u_cvt (
         .i_data (slot_p0[g]),
         .i_scale(scale_c),
         .o_elem (cvt_x[g])
      );
   end

   // p0: block collection; outputs register the converted block during QUANT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt        <= '0;
         max_exp_p0 <= '0;
         last_p0    <= 1'b0;
         slot_p0    <= '0;
         o_X        <= '0;
         o_S        <= '0;
         o_last     <= 1'b0;
      end else begin
         case (state)
            ST_FILL: begin
               if (accept) begin
                  slot_p0[cnt] <= i_data;
                  cnt          <= cnt + CNT_W'(1);
                  last_p0      <= i_last;
                  if (exp_in > max_exp_p0) max_exp_p0 <= exp_in;
               end
            end
            ST_QUANT: begin
               o_X    <= cvt_x;
               o_S    <= scale_c;
               o_last <= last_p0;
            end
            ST_EMIT: begin
               if (i_ready) begin
                  cnt        <= '0;
                  max_exp_p0 <= '0;
                  last_p0    <= 1'b0;
                  slot_p0    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed bench for mx_block_quantizer (k=4, E5M2) with hand-computed expected blocks.
module tb_mx_block_quantizer;

   logic              i_clk   = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_valid = 1'b0;
   logic              i_last  = 1'b0;
   logic              i_ready = 1'b0;
   logic [15:0]       i_data  = 16'h0;
   logic              o_ready;
   logic              o_valid;
   logic              o_last;
   logic [3:0][7:0]   o_X;
   logic [7:0]        o_S;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   mx_block_quantizer #(
      .k(4), .exp_width(5), .man_width(2), .bit_width(8), .scale_width(8)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_data (i_data),
      .i_last (i_last),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_X    (o_X),
      .o_S    (o_S),
      .o_last (o_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      chk("fill.o_ready", o_ready, 1);
      i_valid = 1'b1;
      i_data  = d;
      i_last  = l;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data  = 16'h0;
   endtask

   task automatic send4(input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3, input logic l);
      send(d0, 1'b0);
      send(d1, 1'b0);
      send(d2, 1'b0);
      send(d3, l);
   endtask

   // Called right after the closing accept; optionally stalls in EMIT for 'hold' cycles.
   task automatic expect_block(input string nm, input logic [7:0] s,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic l, input int hold);
      logic [31:0] x;
      x = {e3, e2, e1, e0};
      chk({nm, ".quant_vld"}, o_valid, 0);
      chk({nm, ".quant_rdy"}, o_ready, 0);
      @(posedge i_clk); #1;
      for (int c = 0; c < hold; c++) begin
         chk({nm, ".hold_vld"}, o_valid, 1);
         chk({nm, ".hold_rdy"}, o_ready, 0);
         chk({nm, ".hold_X"}, o_X, x);
         chk({nm, ".hold_S"}, o_S, s);
         @(posedge i_clk); #1;
      end
      chk({nm, ".emit_vld"}, o_valid, 1);
      chk({nm, ".o_S"}, o_S, s);
      chk({nm, ".o_X"}, o_X, x);
      chk({nm, ".o_last"}, o_last, l);
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      chk({nm, ".done_vld"}, o_valid, 0);
      chk({nm, ".done_rdy"}, o_ready, 1);
   endtask

   initial begin
      logic [7:0] x_1375;
      logic [7:0] x_sub;
`ifdef MX_QUANT_RNE_EN
      x_1375 = 8'h7A;
      x_sub  = 8'h02;
`else
      x_1375 = 8'h79;
      x_sub  = 8'h01;
`endif
      repeat (2) @(posedge i_clk); #1;
      chk("rst.o_valid", o_valid, 0);
      chk("rst.o_ready", o_ready, 0);
      chk("rst.o_X", o_X, 0);
      chk("rst.o_S", o_S, 0);
      chk("rst.o_last", o_last, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      chk("rel.o_ready", o_ready, 1);
      @(posedge i_clk); #1;

      send4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
      expect_block("ones", 8'h70, 8'h78, 8'h78, 8'h78, 8'h78, 1'b0, 0);

      send4(16'h3F80, 16'hBF00, 16'h0000, 16'h4000, 1'b0);
      expect_block("mixed", 8'h71, 8'h74, 8'hF0, 8'h00, 8'h78, 1'b0, 0);

      send4(16'h3FB0, 16'h3FB0, 16'h3FB0, 16'h3FB0, 1'b0);
      expect_block("r1375", 8'h70, x_1375, x_1375, x_1375, x_1375, 1'b0, 0);

      send4(16'h3FF0, 16'h3FF0, 16'h3FF0, 16'h3FF0, 1'b0);
      expect_block("sat1875", 8'h70, 8'h7B, 8'h7B, 8'h7B, 8'h7B, 1'b0, 0);

      send(16'h3F80, 1'b0);
      send(16'h4000, 1'b1);
      expect_block("short", 8'h71, 8'h74, 8'h78, 8'h00, 8'h00, 1'b1, 0);

      send4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 1'b1);
      expect_block("lastk", 8'h70, 8'h78, 8'h78, 8'h78, 8'h78, 1'b1, 0);

      send4(16'h3F80, 16'h3080, 16'h30C0, 16'h3060, 1'b0);
      expect_block("subn", 8'h70, 8'h78, 8'h02, 8'h03, x_sub, 1'b0, 0);

      send4(16'h3F80, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0);
      expect_block("infnan", 8'hEF, 8'h00, 8'h7B, 8'hFB, 8'h7B, 1'b0, 0);

      send4(16'h8000, 16'h0000, 16'h0001, 16'h8001, 1'b0);
      expect_block("zeros", 8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0, 0);

      send4(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0);
      expect_block("hold", 8'h71, 8'h78, 8'h78, 8'h78, 8'h78, 1'b0, 5);

      send(16'h3F80, 1'b0);
      send(16'h3F80, 1'b0);
      send(16'h3F80, 1'b0);
      i_rst_n = 1'b0;
      #1;
      chk("mid.o_valid", o_valid, 0);
      chk("mid.o_ready", o_ready, 0);
      chk("mid.o_X", o_X, 0);
      chk("mid.o_S", o_S, 0);
      chk("mid.o_last", o_last, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk); #1;
         chk("mid.idle_vld", o_valid, 0);
      end
      send4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
      expect_block("after", 8'h70, 8'h78, 8'h78, 8'h78, 8'h78, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
